hdc_feature_framer: RTL and testbench

Upstream stage of `hdc_sensor_fusion`. It accepts quantized per-channel features one channel per beat from the sensor front-end and assembles them into the packed `features_top` frame. It presents each frame to the classifier over the `fin_valid`/`fin_ready` handshake. A double buffer lets the next frame fill while the classifier holds the previous one; malformed frames are detected and dropped.

---
 rtl/hdc_pkg.sv | 22 ++
 rtl/hdc_frame_buffer.sv | 43 ++++
 rtl/hdc_feature_framer.sv | 135 +++++++++++++
 tb/tb_hdc_feature_framer.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hdc_pkg.sv
// Shared types and helpers for the HDC sensor-fusion front end.
package hdc_pkg;

   localparam int unsigned DEF_NUM_CHANNEL   = 16;
   localparam int unsigned DEF_CHANNEL_WIDTH = 4;

   typedef enum logic [1:0] {
      FILL    = 2'd0,
      WAIT    = 2'd1,
      DISCARD = 2'd2
   } framer_state_t;

   function automatic int unsigned ceilLog2(input int unsigned v);
      int unsigned r;
      r = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((64'd1 << r) < 64'(v)) r = r + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/hdc_frame_buffer.sv
// Fill/hold register pair: slots are written one at a time into the fill bank,
// and a copy strobe moves the whole fill bank (including a same-cycle write) into hold.
module hdc_frame_buffer #(
   parameter int unsigned NUM_CHANNEL   = 4,
   parameter int unsigned CHANNEL_WIDTH = 2,
   parameter int unsigned IDX_W         = 2
) (
   input  logic                                 clk_i,
   input  logic                                 rst_ni,
   input  logic                                 wr_en_i,
   input  logic [IDX_W-1:0]                     wr_idx_i,
   input  logic [CHANNEL_WIDTH-1:0]             wr_data_i,
   input  logic                                 copy_i,
   output logic [NUM_CHANNEL*CHANNEL_WIDTH-1:0] hold_o
);

   logic [NUM_CHANNEL*CHANNEL_WIDTH-1:0] fill_q, fill_d;
   logic [NUM_CHANNEL*CHANNEL_WIDTH-1:0] hold_q, hold_d;

   always_comb begin
      fill_d = fill_q;
      for (int unsigned k = 0; k < NUM_CHANNEL; k++) begin
         if (wr_en_i && (wr_idx_i == IDX_W'(k))) begin
            fill_d[k*CHANNEL_WIDTH +: CHANNEL_WIDTH] = wr_data_i;
         end
      end
      // Copy takes the post-write view so the completing beat lands in hold.
      hold_d = copy_i ? fill_d : hold_q;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         fill_q <= '0;
         hold_q <= '0;
      end else begin
         fill_q <= fill_d;
         hold_q <= hold_d;
      end
   end

   assign hold_o = hold_q;

endmodule

// File: rtl/hdc_feature_framer.sv
// Assembles per-channel feature beats into packed frames, double-buffered
// towards the classifier; short and long frames are dropped and counted.
module hdc_feature_framer
   import hdc_pkg::*;
#(
   parameter int unsigned NUM_CHANNEL   = DEF_NUM_CHANNEL,
   parameter int unsigned CHANNEL_WIDTH = DEF_CHANNEL_WIDTH,
   parameter int unsigned ERR_CNT_WIDTH = 8
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic [CHANNEL_WIDTH-1:0]             ch_data,
   input  logic                                 ch_valid,
   input  logic                                 ch_last,
   output logic                                 ch_ready,
   output logic [NUM_CHANNEL*CHANNEL_WIDTH-1:0] features_top,
   output logic                                 fin_valid,
   input  logic                                 fin_ready,
   output logic                                 frame_err,
   output logic [ERR_CNT_WIDTH-1:0]             err_cnt
);

   localparam int unsigned IDX_W = ceilLog2(NUM_CHANNEL);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHANNEL - 1);

   framer_state_t            state_q, state_d;
   logic [IDX_W-1:0]         idx_q, idx_d;
   logic                     hold_full_q, hold_full_d;
   logic                     ch_ready_q, ch_ready_d;
   logic                     frame_err_q, frame_err_d;
   logic [ERR_CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;
   logic                     accept, wr_en, copy;

   assign accept = ch_valid && ch_ready_q;
   assign wr_en  = accept && (state_q == FILL);

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      copy        = 1'b0;
      frame_err_d = 1'b0;
      unique case (state_q)
         FILL: begin
            if (accept) begin
               if (idx_q != LAST_IDX) begin
                  if (ch_last) begin
                     frame_err_d = 1'b1;
                     idx_d       = '0;
                  end else begin
                     idx_d = idx_q + IDX_W'(1);
                  end
               end else if (ch_last) begin
                  if (!hold_full_q || fin_ready) begin
                     copy  = 1'b1;
                     idx_d = '0;
                  end else begin
                     state_d = WAIT;
                  end
               end else begin
                  frame_err_d = 1'b1;
                  state_d     = DISCARD;
               end
            end
         end
         WAIT: begin
            if (fin_ready) begin
               copy    = 1'b1;
               idx_d   = '0;
               state_d = FILL;
            end
         end
         DISCARD: begin
            if (accept && ch_last) begin
               idx_d   = '0;
               state_d = FILL;
            end
         end
         default: begin
            state_d = FILL;
            idx_d   = '0;
         end
      endcase

      // A refill on the drain edge keeps the hold bank occupied.
      if (copy) begin
         hold_full_d = 1'b1;
      end else if (hold_full_q && fin_ready) begin
         hold_full_d = 1'b0;
      end else begin
         hold_full_d = hold_full_q;
      end

      ch_ready_d = (state_d != WAIT);
      err_cnt_d  = (frame_err_d && (err_cnt_q != '1)) ? err_cnt_q + ERR_CNT_WIDTH'(1)
                                                       : err_cnt_q;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= FILL;
         idx_q       <= '0;
         hold_full_q <= 1'b0;
         ch_ready_q  <= 1'b0;
         frame_err_q <= 1'b0;
         err_cnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         hold_full_q <= hold_full_d;
         ch_ready_q  <= ch_ready_d;
         frame_err_q <= frame_err_d;
         err_cnt_q   <= err_cnt_d;
      end
   end

   hdc_frame_buffer #(
      .NUM_CHANNEL   (NUM_CHANNEL),
      .CHANNEL_WIDTH (CHANNEL_WIDTH),
      .IDX_W         (IDX_W)
   ) u_buf (
      .clk_i     (clk),
      .rst_ni    (rst),
      .wr_en_i   (wr_en),
      .wr_idx_i  (idx_q),
      .wr_data_i (ch_data),
      .copy_i    (copy),
      .hold_o    (features_top)
   );

   assign ch_ready  = ch_ready_q;
   assign fin_valid = hold_full_q;
   assign frame_err = frame_err_q;
   assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_hdc_feature_framer.sv
// Randomized and directed bench for hdc_feature_framer against a beat-queue reference model.
module tb_hdc_feature_framer;

   localparam int unsigned N  = 4;
   localparam int unsigned CW = 2;
   localparam int unsigned EW = 3;
   localparam int unsigned FW = N * CW;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [CW-1:0] ch_data = '0;
   logic          ch_valid = 1'b0;
   logic          ch_last = 1'b0;
   logic          ch_ready;
   logic [FW-1:0] features_top;
   logic          fin_valid;
   logic          fin_ready = 1'b0;
   logic          frame_err;
   logic [EW-1:0] err_cnt;

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;

   always #5 clk = ~clk;

   hdc_feature_framer #(
      .NUM_CHANNEL   (N),
      .CHANNEL_WIDTH (CW),
      .ERR_CNT_WIDTH (EW)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .ch_data      (ch_data),
      .ch_valid     (ch_valid),
      .ch_last      (ch_last),
      .ch_ready     (ch_ready),
      .features_top (features_top),
      .fin_valid    (fin_valid),
      .fin_ready    (fin_ready),
      .frame_err    (frame_err),
      .err_cnt      (err_cnt)
   );

   // Reference model: beats of the frame under construction, a frame parked
   // while the hold slot is busy, and the frame currently offered downstream.
   logic [CW-1:0] cur_beats[$];
   logic [FW-1:0] pend_f, held_f;
   bit            dropping, waiting, hold_full, m_ready, m_err;
   int unsigned   m_cnt;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [FW-1:0] pack_beats();
      logic [FW-1:0] f;
      f = '0;
      foreach (cur_beats[k]) f = f | (FW'(cur_beats[k]) << (k * CW));
      return f;
   endfunction

   function automatic void model_reset();
      cur_beats.delete();
      pend_f    = '0;
      held_f    = '0;
      dropping  = 0;
      waiting   = 0;
      hold_full = 0;
      m_ready   = 0;
      m_err     = 0;
      m_cnt     = 0;
   endfunction

   function automatic void model_edge();
      bit            copy, err;
      logic [FW-1:0] cf;
      copy = 0;
      err  = 0;
      cf   = '0;
      if (waiting) begin
         if (fin_ready) begin
            copy    = 1;
            cf      = pend_f;
            waiting = 0;
         end
      end else if (ch_valid && m_ready) begin
         if (dropping) begin
            if (ch_last) dropping = 0;
         end else begin
            cur_beats.push_back(ch_data);
            if (cur_beats.size() < N) begin
               if (ch_last) begin
                  err = 1;
                  cur_beats.delete();
               end
            end else if (ch_last) begin
               if (!hold_full || fin_ready) begin
                  copy = 1;
                  cf   = pack_beats();
               end else begin
                  waiting = 1;
                  pend_f  = pack_beats();
               end
               cur_beats.delete();
            end else begin
               err      = 1;
               dropping = 1;
               cur_beats.delete();
            end
         end
      end
      if (copy) begin
         held_f    = cf;
         hold_full = 1;
      end else if (fin_ready) begin
         hold_full = 0;
      end
      m_ready = !waiting;
      m_err   = err;
      if (err && m_cnt < (2 ** EW) - 1) m_cnt++;
   endfunction

   task automatic check_all();
      check_eq("ch_ready",  32'(ch_ready),     32'(m_ready));
      check_eq("fin_valid", 32'(fin_valid),    32'(hold_full));
      check_eq("features",  32'(features_top), 32'(held_f));
      check_eq("frame_err", 32'(frame_err),    32'(m_err));
      check_eq("err_cnt",   32'(err_cnt),      m_cnt);
   endtask

   task automatic cycle();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_all();
   endtask

   task automatic beat(input logic [CW-1:0] d, input bit last);
      ch_valid = 1'b1;
      ch_data  = d;
      ch_last  = last;
      cycle();
      ch_valid = 1'b0;
      ch_last  = 1'b0;
   endtask

   task automatic idle(input int unsigned n);
      for (int unsigned i = 0; i < n; i++) cycle();
   endtask

   int unsigned fr_pct;
   bit          nat_last;

   initial begin
      model_reset();
      #1;
      check_eq("rst_ready",  32'(ch_ready),     32'd0);
      check_eq("rst_valid",  32'(fin_valid),    32'd0);
      check_eq("rst_feat",   32'(features_top), 32'd0);
      check_eq("rst_err",    32'(frame_err),    32'd0);
      check_eq("rst_errcnt", 32'(err_cnt),      32'd0);
      @(negedge clk);
      rst = 1'b1;
      idle(1);
      check_eq("ready_after_rst", 32'(ch_ready), 32'd1);

      // Basic frame, classifier always ready.
      fin_ready = 1'b1;
      beat(2'd3, 0); beat(2'd2, 0); beat(2'd1, 0);
      check_eq("t1_valid_early", 32'(fin_valid), 32'd0);
      beat(2'd0, 1);
      check_eq("t1_valid", 32'(fin_valid), 32'd1);
      check_eq("t1_feat", 32'(features_top), 32'h1B);
      idle(2);

      // Back-pressure: second frame parks in fill until the classifier accepts.
      fin_ready = 1'b0;
      beat(2'd1, 0); beat(2'd2, 0); beat(2'd3, 0); beat(2'd0, 1);
      beat(2'd2, 0); beat(2'd2, 0); beat(2'd0, 0); beat(2'd1, 1);
      check_eq("t2_ready_low", 32'(ch_ready), 32'd0);
      check_eq("t2_first_held", 32'(features_top), 32'h39);
      idle(3);
      fin_ready = 1'b1;
      idle(1);
      check_eq("t2_second", 32'(features_top), 32'h4A);
      check_eq("t2_ready_back", 32'(ch_ready), 32'd1);
      idle(2);

      // Short frame then a good one.
      beat(2'd1, 0); beat(2'd2, 1);
      check_eq("t3_err", 32'(frame_err), 32'd1);
      check_eq("t3_cnt", 32'(err_cnt), 32'd1);
      beat(2'd0, 0); beat(2'd1, 0); beat(2'd2, 0); beat(2'd3, 1);
      check_eq("t3_good", 32'(features_top), 32'hE4);

      // Long frame: six beats, last only on the sixth.
      fin_ready = 1'b1;
      idle(2);
      for (int unsigned i = 0; i < 6; i++) beat(CW'(i), i == 5);
      check_eq("t4_cnt", 32'(err_cnt), 32'd2);
      check_eq("t4_valid", 32'(fin_valid), 32'd0);

      // Asynchronous reset with a held frame and a partial frame in flight.
      fin_ready = 1'b0;
      beat(2'd3, 0); beat(2'd3, 0); beat(2'd3, 0); beat(2'd3, 1);
      beat(2'd1, 0); beat(2'd1, 0);
      rst = 1'b0;
      #1;
      check_eq("t5_valid", 32'(fin_valid), 32'd0);
      check_eq("t5_feat", 32'(features_top), 32'd0);
      check_eq("t5_ready", 32'(ch_ready), 32'd0);
      model_reset();
      @(negedge clk);
      rst = 1'b1;
      idle(1);
      beat(2'd2, 0); beat(2'd0, 0); beat(2'd3, 0); beat(2'd1, 1);
      check_eq("t5_good", 32'(features_top), 32'h72);

      // Random traffic with varying downstream back-pressure.
      for (int unsigned ph = 0; ph < 4; ph++) begin
         fr_pct = 20 + 25 * ph;
         for (int unsigned c = 0; c < 1500; c++) begin
            fin_ready = ($urandom_range(0, 99) < fr_pct);
            ch_valid  = ($urandom_range(0, 3) != 0);
            ch_data   = CW'($urandom);
            nat_last  = dropping ? ($urandom_range(0, 2) == 0) : (cur_beats.size() == N - 1);
            ch_last   = ($urandom_range(0, 11) == 0) ? !nat_last : nat_last;
            cycle();
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
